// File: rtl/cmp_conv_pkg.sv
// Shared types and encodings for the comparator conversion controller.
package cmp_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [1:0] COMP_EQ  = 2'b00;
    localparam logic [1:0] COMP_LT  = 2'b01;
    localparam logic [1:0] COMP_GT  = 2'b10;
    localparam logic [1:0] COMP_BAD = 2'b11;

    localparam logic MODE_RAMP = 1'b0;
    localparam logic MODE_SAR  = 1'b1;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times how long a DAC trial code is held before sampling.
module settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] count_q;

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= LOAD_VAL;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/cmp_conv_ctrl.sv
// Conversion controller: sequences DAC trial codes, samples the comparator and
// resolves a WIDTH-bit result by linear ramp or successive approximation.
module cmp_conv_ctrl
    import cmp_conv_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [1:0]       comp_out,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err,
    output logic [3:0]       conv_count
);

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q;
    logic             mode_q;
    logic [WIDTH-1:0] dac_code_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             exact_q;
    logic             err_q;
    logic [3:0]       conv_count_q;

    logic             fin_d;
    logic             abort_d;
    logic             exact_d;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] next_code_d;
    logic [WIDTH-1:0] kept_code;

    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_expired;

    // Verdict for the current trial; only consumed on the SAMPLE edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        fin_d       = 1'b0;
        abort_d     = 1'b0;
        exact_d     = 1'b0;
        result_d    = dac_code_q;
        next_code_d = dac_code_q;
        kept_code   = dac_code_q;

        if (comp_out == COMP_BAD) begin
            fin_d    = 1'b1;
            abort_d  = 1'b1;
            result_d = ZERO;
        end else if (mode_q == MODE_RAMP) begin
            case (comp_out)
                COMP_EQ: begin
                    fin_d   = 1'b1;
                    exact_d = 1'b1;
                end
                COMP_LT: begin
                    fin_d    = 1'b1;
                    result_d = (dac_code_q == ZERO) ? ZERO : dac_code_q - ONE;
                end
                default: begin
                    if (dac_code_q == ALL_ONES) begin
                        fin_d = 1'b1;
                    end else begin
                        next_code_d = dac_code_q + ONE;
                    end
                end
            endcase
        end else begin
            // mask_q marks the bit under test; bits below it are still zero.
            if (comp_out == COMP_LT) begin
                kept_code = dac_code_q & ~mask_q;
            end
            if (comp_out == COMP_EQ) begin
                fin_d   = 1'b1;
                exact_d = 1'b1;
            end else if (mask_q[0]) begin
                fin_d    = 1'b1;
                result_d = kept_code;
            end else begin
                next_code_d = kept_code | (mask_q >> 1);
            end
        end
    end

    assign tmr_load = ((state_q == ST_IDLE) && start) ||
                      ((state_q == ST_SAMPLE) && !fin_d);
    assign tmr_en   = (state_q == ST_SETTLE);

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_RAMP;
            dac_code_q   <= ZERO;
            mask_q       <= ZERO;
            result_q     <= ZERO;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            exact_q      <= 1'b0;
            err_q        <= 1'b0;
            conv_count_q <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_SETTLE;
                        mode_q     <= mode;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        mask_q     <= MSB_ONLY;
                        dac_code_q <= (mode == MODE_SAR) ? MSB_ONLY : ZERO;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_expired) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (fin_d) begin
                        state_q    <= ST_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        dac_code_q <= ZERO;
                        result_q   <= result_d;
                        exact_q    <= exact_d;
                        err_q      <= abort_d;
                        if (!abort_d) begin
                            conv_count_q <= conv_count_q + 4'd1;
                        end
                    end else begin
                        state_q    <= ST_SETTLE;
                        dac_code_q <= next_code_d;
                        mask_q     <= mask_q >> 1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dac_code   = dac_code_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign exact      = exact_q;
    assign err        = err_q;
    assign conv_count = conv_count_q;

endmodule

// File: doc/cmp_conv_ctrl.md
# cmp_conv_ctrl

Conversion controller that sequences the 2-bit magnitude-comparator datapath. It drives a DAC trial code, waits a fixed settling time, samples the comparator verdict and resolves an N-bit result. Two algorithms are supported: linear ramp and successive approximation (SAR). It sits between the comparator/DAC front end and the counter/display logic, and hands off one result per start request.

## Interface
- WIDTH, 4, resolution of the DAC code and result (≥2)
- SETTLE, 2, cycles the DAC code is held before the comparator is sampled (≥1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  conversion request; honoured only in IDLE
- mode  in  1  0 = ramp, 1 = SAR; captured when start is accepted
- comp_out  in  2  comparator verdict for the current dac_code: 10 = input above code, 01 = input below code, 00 = equal, 11 = invalid
- dac_code  out  WIDTH  trial code to the DAC
- busy  out  1  conversion in progress
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  last converted value; held until next done
- exact  out  1  last conversion terminated on equality (00)
- err  out  1  last conversion aborted on 11; held until next accepted start
- conv_count  out  4  completed non-error conversions, wraps 15→0

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE with start=1: latch mode, clear err, load the first trial (ramp: 0; SAR: MSB only), enter SETTLE.
- SETTLE: hold dac_code for SETTLE cycles, then go to SAMPLE for one cycle, in which comp_out is registered and acted on.
- Ramp decision:
  - 00 → result=dac_code, exact=1.
  - 01 → result=dac_code-1, saturating at 0; exact=0.
  - 10 with dac_code=all-ones → result=all-ones, exact=0 (overrange).
  - 10 otherwise → dac_code+1, back to SETTLE.
- SAR decision, for bit i from MSB down:
  - 10 → keep bit i.
  - 01 → clear bit i.
  - 00 → keep bit i, lower bits zero, finish with exact=1.
  - After bit 0 → finish with exact=0.
  - Next trial = kept bits | (1<<(i-1)).
- comp_out=11 in SAMPLE (either mode) → abort: err=1, result=0, exact=0, conv_count unchanged.
- Finish/abort → DONE for one cycle, then IDLE unconditionally. conv_count increments on entry to DONE when err=0.
- start during SETTLE/SAMPLE/DONE is ignored. mode changes after acceptance are ignored.
- comp_out is ignored outside SAMPLE.

## Timing
- Reset (async assert, any state): state=IDLE, dac_code=0, busy=0, done=0, result=0, exact=0, err=0, conv_count=0. Release is synchronous to clk; the first start can be accepted on the first edge after release.
- Start accepted at edge t → busy=1 and the first dac_code valid from t to the edge that enters DONE.
- Each trial lasts SETTLE+1 cycles. comp_out is sampled on the last edge of the trial.
- SAR latency: WIDTH·(SETTLE+1) busy cycles, or fewer on an early 00.
- Ramp latency: (k+1)·(SETTLE+1) busy cycles, where k is the final trial code.
- done=1 and busy=0 in the DONE cycle. result, exact and err are valid from that cycle. dac_code=0 whenever busy=0.
- Start held high: a new conversion is accepted on the cycle after DONE.

## Structure
- Package cmp_conv_pkg holds:
  - the state enum;
  - comparator codes COMP_EQ=2'b00, COMP_LT=2'b01, COMP_GT=2'b10, COMP_BAD=2'b11;
  - the mode constants MODE_RAMP and MODE_SAR.
- Sub-module settle_timer: loadable down-counter sized to SETTLE, with a load/expire interface used by the SETTLE state.
- Trial-code generation (ramp increment and SAR bit mask) stays in the top level.

## Test plan
All scenarios use WIDTH=4, SETTLE=2 and a behavioural comparator model driven by an analog value vin.
- SAR, vin=11 → trials 8,12,10,11; 00 at 11 → result=11, exact=1, 12 busy cycles, done pulse, conv_count=1.
- SAR, vin=10.5 → trials 8,12,10,11 → result=10, exact=0, 12 busy cycles.
- Ramp, vin=3 → codes 0..3 → result=3, exact=1, 12 busy cycles. Ramp, vin=15.5 → result=15, exact=0, 48 busy cycles.
- SAR with 11 forced on the second sample → err=1, result=0, done pulse at cycle 6, conv_count unchanged. err clears on the next accepted start.
- start held high, mode toggled mid-conversion → back-to-back conversions, each using the mode latched at its own start. No second start is accepted while busy. conv_count wraps 15→0 after 16 conversions.
- rst_n pulled low during SAR trial 3 → all outputs 0 immediately, without waiting for a clock. After release, the controller is in IDLE and a fresh start converts correctly.
